// File: rtl/ramb4_s16_serial_reader_if.sv
// Signal bundle around the serial reader: command side, RAM read port and
// serial output stream. The reader itself uses the master modport.
interface ramb4_s16_serial_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 9
);
  // Command side
  logic              START;
  logic [ADDR_W-1:0] START_ADDR;
  logic [CNT_W-1:0]  WORD_COUNT;
  logic              BUSY;
  logic              DONE;
  // RAM read port
  logic [ADDR_W-1:0] ADDRB;
  logic              ENB;
  logic              WEB;
  logic              RAM_RST;
  logic [DATA_W-1:0] DOB;
  // Serial stream
  logic              SDO;
  logic              SVALID;
  logic              SREADY;
  logic              SLAST;

  modport master (
    input  START, START_ADDR, WORD_COUNT, DOB, SREADY,
    output BUSY, DONE, ADDRB, ENB, WEB, RAM_RST, SDO, SVALID, SLAST
  );

  modport slave (
    output START, START_ADDR, WORD_COUNT, DOB, SREADY,
    input  BUSY, DONE, ADDRB, ENB, WEB, RAM_RST, SDO, SVALID, SLAST
  );
endinterface

// File: rtl/ramb4_s16_serial_reader.sv
// Reads a run of consecutive 16-bit words from a block RAM read port and
// streams them LSB first as a 1-bit valid/ready stream. A one-word prefetch
// buffer keeps the stream free of bubbles while the consumer is always ready.
module ramb4_s16_serial_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 9
) (
  input logic                        CLKA,
  input logic                        RSTB,
  ramb4_s16_serial_reader_if.master  bus
);

  localparam int              BIT_W      = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] PENULT_BIT = BIT_W'(DATA_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_enb;
  logic [ADDR_W-1:0] r_addrb;
  logic              r_dvld;      // DOB carries the word read on the previous cycle
  logic [CNT_W-1:0]  r_count;     // captured run length
  logic [CNT_W-1:0]  r_issued;    // words requested from the RAM
  logic [CNT_W-1:0]  r_loaded;    // words moved into the shift register
  logic [DATA_W-1:0] r_sh;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_buf;
  logic              r_buf_full;
  logic              r_svalid;
  logic              r_slast;

  logic              w_hs;
  logic              w_fetch;
  logic              w_next_avail;
  logic [DATA_W-1:0] w_next_word;

  assign w_hs         = r_svalid & bus.SREADY;
  // One read in flight at most, and only into an empty buffer.
  assign w_fetch      = (r_state == S_STREAM) && !r_buf_full && !r_enb && !r_dvld
                        && (r_issued < r_count);
  // The next word comes from the buffer, or straight off DOB if it lands now.
  assign w_next_avail = r_buf_full | r_dvld;
  assign w_next_word  = r_buf_full ? r_buf : bus.DOB;

  assign bus.BUSY    = r_busy;
  assign bus.DONE    = r_done;
  assign bus.ADDRB   = r_addrb;
  assign bus.ENB     = r_enb;
  assign bus.WEB     = 1'b0;
  assign bus.RAM_RST = 1'b0;
  assign bus.SDO     = r_sh[0];
  assign bus.SVALID  = r_svalid;
  assign bus.SLAST   = r_slast;

  // Control FSM, RAM read sequencing, prefetch buffer and serializer.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see the new value.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_enb      <= 1'b0;
      r_addrb    <= '0;
      r_dvld     <= 1'b0;
      r_count    <= '0;
      r_issued   <= '0;
      r_loaded   <= '0;
      r_sh       <= '0;
      r_bit      <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_svalid   <= 1'b0;
      r_slast    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_enb  <= 1'b0;
      r_dvld <= r_enb;

      unique case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_count <= bus.WORD_COUNT;
            if (bus.WORD_COUNT == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state    <= S_PRIME;
              r_busy     <= 1'b1;
              r_enb      <= 1'b1;
              r_addrb    <= bus.START_ADDR;
              r_issued   <= CNT_W'(1);
              r_loaded   <= '0;
              r_buf_full <= 1'b0;
            end
          end
        end

        S_PRIME: begin
          if (r_dvld) begin
            r_sh     <= bus.DOB;
            r_bit    <= '0;
            r_svalid <= 1'b1;
            r_slast  <= 1'b0;
            r_loaded <= CNT_W'(1);
            r_state  <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (w_fetch) begin
            r_enb    <= 1'b1;
            r_addrb  <= r_addrb + 1'b1;
            r_issued <= r_issued + 1'b1;
          end

          if (w_hs && (r_bit != LAST_BIT)) begin
            // Mid-word: shift out the next bit, park any returning read.
            r_sh  <= r_sh >> 1;
            r_bit <= r_bit + 1'b1;
            if ((r_bit == PENULT_BIT) && (r_loaded == r_count)) r_slast <= 1'b1;
            if (r_dvld) begin
              r_buf      <= bus.DOB;
              r_buf_full <= 1'b1;
            end
          end else if (w_hs && r_slast) begin
            // Final bit of the run accepted.
            r_state  <= S_IDLE;
            r_svalid <= 1'b0;
            r_slast  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (w_hs || !r_svalid) begin
            // Word boundary, or waiting out a bubble for the next word.
            if (w_next_avail) begin
              r_sh       <= w_next_word;
              r_buf_full <= 1'b0;
              r_bit      <= '0;
              r_svalid   <= 1'b1;
              r_loaded   <= r_loaded + 1'b1;
            end else begin
              r_svalid <= 1'b0;
            end
          end else if (r_dvld) begin
            r_buf      <= bus.DOB;
            r_buf_full <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramb4_s16_serial_reader.sv
// Bench for ramb4_s16_serial_reader: behavioural RAM, stream monitor and a
// word-level reference (stream = RAM[(addr+w) mod 256] bits, LSB first).
module tb_ramb4_s16_serial_reader;

  logic CLKA = 1'b0;
  logic RSTB;

  always #5 CLKA = ~CLKA;

  ramb4_s16_serial_reader_if bus ();

  ramb4_s16_serial_reader dut (
    .CLKA (CLKA),
    .RSTB (RSTB),
    .bus  (bus)
  );

  // Behavioural RAM read port: data appears the cycle after the enable cycle.
  logic [15:0] mem [256];
  always @(posedge CLKA) if (bus.ENB) bus.DOB <= mem[bus.ADDRB];

  int cyc = 0;
  always @(posedge CLKA) cyc <= cyc + 1;

  // Stream / RAM-port monitor, sampled on the falling edge.
  logic       mon_clr = 1'b0;
  logic [7:0] enb_q [$];
  logic       bit_q [$];
  logic       last_q [$];
  int  enb_consec, sv_cnt, first_sv, last_sv, done_cnt, done_cyc, last_hs_cyc, hold_err;
  logic busy_at_done, busy_seen, prev_enb, prev_hold, prev_sdo, prev_slast;

  always @(negedge CLKA) begin
    if (mon_clr) begin
      enb_q.delete();
      bit_q.delete();
      last_q.delete();
      enb_consec   <= 0;
      sv_cnt       <= 0;
      first_sv     <= 0;
      last_sv      <= 0;
      done_cnt     <= 0;
      done_cyc     <= 0;
      last_hs_cyc  <= 0;
      hold_err     <= 0;
      busy_at_done <= 1'b0;
      busy_seen    <= 1'b0;
      prev_enb     <= 1'b0;
      prev_hold    <= 1'b0;
      prev_sdo     <= 1'b0;
      prev_slast   <= 1'b0;
    end else begin
      if (bus.ENB) begin
        enb_q.push_back(bus.ADDRB);
        if (prev_enb) enb_consec <= enb_consec + 1;
      end
      prev_enb <= bus.ENB;
      if (prev_hold && (bus.SVALID !== 1'b1 || bus.SDO !== prev_sdo || bus.SLAST !== prev_slast))
        hold_err <= hold_err + 1;
      prev_hold  <= bus.SVALID && !bus.SREADY;
      prev_sdo   <= bus.SDO;
      prev_slast <= bus.SLAST;
      if (bus.SVALID && bus.SREADY) begin
        bit_q.push_back(bus.SDO);
        last_q.push_back(bus.SLAST);
        last_hs_cyc <= cyc;
      end
      if (bus.SVALID) begin
        sv_cnt <= sv_cnt + 1;
        if (sv_cnt == 0) first_sv <= cyc;
        last_sv <= cyc;
      end
      if (bus.DONE) begin
        done_cnt     <= done_cnt + 1;
        done_cyc     <= cyc;
        busy_at_done <= bus.BUSY;
      end
      if (bus.BUSY) busy_seen <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    @(posedge CLKA); #1;
    mon_clr = 1'b1;
    @(negedge CLKA); #1;
    mon_clr = 1'b0;
  endtask

  // Assemble streamed word w (LSB first) from the monitor's bit queue.
  function automatic logic [15:0] got_word(input int w);
    logic [15:0] g = '0;
    for (int b = 0; b < 16; b++)
      if (16 * w + b < bit_q.size()) g[b] = bit_q[16 * w + b];
    return g;
  endfunction

  // One START run. rdy_mode: 0 always ready, 1 random, 2 pattern 1,0,0.
  task automatic run(input string name, input logic [7:0] addr, input int n,
                     input int rdy_mode, input bit poke_start);
    int start_cyc;
    int budget;
    int bad_addr;
    int bad_words;
    int n_last;
    clear_mon();
    @(posedge CLKA); #1;
    bus.START      = 1'b1;
    bus.START_ADDR = addr;
    bus.WORD_COUNT = 9'(n);
    bus.SREADY     = (rdy_mode != 2);
    @(posedge CLKA); #1;
    start_cyc = cyc;
    bus.START = 1'b0;
    budget = 64 * n + 50;
    for (int c = 0; c < budget && done_cnt == 0; c++) begin
      case (rdy_mode)
        0:       bus.SREADY = 1'b1;
        1:       bus.SREADY = 1'($urandom_range(0, 1));
        default: bus.SREADY = ((c % 3) == 2);
      endcase
      if (poke_start && c == 8) begin
        bus.START      = 1'b1;
        bus.START_ADDR = 8'h99;
        bus.WORD_COUNT = 9'd5;
      end else begin
        bus.START = 1'b0;
      end
      @(posedge CLKA); #1;
    end
    bus.START  = 1'b0;
    bus.SREADY = 1'b1;
    repeat (4) @(posedge CLKA);
    #1;

    bad_addr = 0;
    for (int i = 0; i < enb_q.size(); i++)
      if (enb_q[i] !== 8'(int'(addr) + i)) bad_addr++;
    bad_words = 0;
    for (int w = 0; w < n; w++)
      if (got_word(w) !== mem[8'(int'(addr) + w)]) bad_words++;
    n_last = 0;
    foreach (last_q[i]) if (last_q[i]) n_last++;

    check({name, ":done_count"}, done_cnt, 1);
    check({name, ":busy_at_done"}, busy_at_done, 0);
    check({name, ":done_after_last_bit"}, done_cyc - last_hs_cyc, 1);
    check({name, ":enb_pulses"}, enb_q.size(), n);
    check({name, ":enb_back_to_back"}, enb_consec, 0);
    check({name, ":enb_addrs_bad"}, bad_addr, 0);
    check({name, ":bit_count"}, bit_q.size(), 16 * n);
    check({name, ":words_bad"}, bad_words, 0);
    check({name, ":slast_count"}, n_last, 1);
    check({name, ":slast_on_final"}, (last_q.size() > 0) ? last_q[last_q.size() - 1] : 1'b0, 1);
    check({name, ":hold_violations"}, hold_err, 0);
    check({name, ":busy_end"}, bus.BUSY, 0);
    if (rdy_mode == 0) begin
      check({name, ":svalid_cycles"}, sv_cnt, 16 * n);
      check({name, ":svalid_contiguous"}, last_sv - first_sv + 1, 16 * n);
      check({name, ":first_bit_latency"}, first_sv - start_cyc, 2);
    end
  endtask

  initial begin
    int sc;
    logic [7:0] ra;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    // Reset state
    RSTB           = 1'b1;
    bus.START      = 1'b0;
    bus.START_ADDR = '0;
    bus.WORD_COUNT = '0;
    bus.SREADY     = 1'b0;
    repeat (3) @(posedge CLKA);
    @(negedge CLKA);
    check("reset:outputs", {bus.BUSY, bus.DONE, bus.ENB, bus.SDO, bus.SVALID, bus.SLAST,
                            bus.WEB, bus.RAM_RST}, 8'h00);
    check("reset:addrb", bus.ADDRB, 8'h00);
    RSTB = 1'b0;

    // Single word
    mem[8'h10] = 16'hA5C3;
    run("single", 8'h10, 1, 0, 1'b0);
    check("single:word_bits", got_word(0), 16'hA5C3);

    // Three words across word boundaries
    mem[8'h20] = 16'h0001;
    mem[8'h21] = 16'h8000;
    mem[8'h22] = 16'hFFFF;
    run("three", 8'h20, 3, 0, 1'b0);
    check("three:bit0", (bit_q.size() > 0) ? bit_q[0] : 1'b0, 1);
    check("three:bit31", (bit_q.size() > 31) ? bit_q[31] : 1'b0, 1);
    check("three:bit30", (bit_q.size() > 30) ? bit_q[30] : 1'b1, 0);

    // Backpressure on a single word
    run("backpressure", 8'h10, 1, 2, 1'b0);
    check("backpressure:word_bits", got_word(0), 16'hA5C3);

    // Address wrap
    run("wrap", 8'hFF, 2, 0, 1'b0);

    // Zero count
    clear_mon();
    @(posedge CLKA); #1;
    bus.START      = 1'b1;
    bus.START_ADDR = 8'h33;
    bus.WORD_COUNT = 9'd0;
    @(posedge CLKA); #1;
    sc = cyc;
    bus.START = 1'b0;
    repeat (4) @(posedge CLKA);
    #1;
    check("zero:done_count", done_cnt, 1);
    check("zero:done_cycle", done_cyc - sc, 0);
    check("zero:enb_pulses", enb_q.size(), 0);
    check("zero:busy_seen", busy_seen, 0);

    // START while busy is ignored
    run("busy_start", 8'h40, 2, 0, 1'b1);

    // Random runs with random backpressure
    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom);
      run("random", ra, $urandom_range(1, 6), 1, 1'b0);
    end

    // Full RAM run
    ra = 8'($urandom);
    run("full256", ra, 256, 0, 1'b0);

    // Reset mid-stream
    clear_mon();
    @(posedge CLKA); #1;
    bus.START      = 1'b1;
    bus.START_ADDR = 8'h80;
    bus.WORD_COUNT = 9'd4;
    bus.SREADY     = 1'b1;
    @(posedge CLKA); #1;
    bus.START = 1'b0;
    for (int c = 0; c < 100 && bit_q.size() < 5; c++) @(negedge CLKA);
    check("rst:reached_5_bits", bit_q.size(), 5);
    RSTB = 1'b1;
    @(posedge CLKA);
    @(negedge CLKA);
    check("rst:outputs", {bus.BUSY, bus.DONE, bus.ENB, bus.SDO, bus.SVALID, bus.SLAST,
                          bus.WEB, bus.RAM_RST}, 8'h00);
    check("rst:addrb", bus.ADDRB, 8'h00);
    RSTB = 1'b0;
    clear_mon();
    repeat (20) @(posedge CLKA);
    #1;
    check("rst:no_enb_after", enb_q.size(), 0);
    check("rst:no_done_after", done_cnt, 0);
    check("rst:busy_after", busy_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
